input_debounce_4: RTL

//  Four-channel input conditioner for raw switch/button lines on the FPGA board.

---
 rtl/input_debounce_4_pkg.sv | 18 +
 rtl/input_debounce_4_channel.sv | 67 ++++++
 rtl/input_debounce_4.sv | 91 +++++++++
 3 files changed

// File: rtl/input_debounce_4_pkg.sv
// Shared constants and types for the four-channel input debouncer.
// Channel order follows merge_bits: D is the MSB, A is the LSB.
package input_pkg;

    localparam int NUM_CH = 4;
    localparam int CH_D   = 3;
    localparam int CH_C   = 2;
    localparam int CH_B   = 1;
    localparam int CH_A   = 0;

    typedef logic [NUM_CH-1:0] nibble_t;

    // The counter must be able to hold DEBOUNCE_CYCLES-1.
    function automatic int cntWidth(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/input_debounce_4_channel.sv
// One input channel: a reset-able synchroniser chain followed by a
// mismatch counter that commits the stable bit. Edge direction only with INPUT_EDGE_EN.
module debounce_channel
    import input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic q,
    output logic commit
`ifdef INPUT_EDGE_EN
    ,
    output logic dir
`endif
);

    localparam int CNT_W = cntWidth(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic [CNT_W-1:0]       cnt_r;
    logic                   stable_r;
    logic                   synced_s;
    logic [CNT_W-1:0]       cntNext_s;
    logic                   stableNext_s;
    logic                   commit_s;

    // Counter and stable-bit next state; progress is lost whenever the input agrees again.
    always_comb begin
        synced_s     = sync_r[SYNC_STAGES-1];
        cntNext_s    = cnt_r;
        stableNext_s = stable_r;
        commit_s     = 1'b0;
        if (synced_s == stable_r) begin
            cntNext_s = {CNT_W{1'b0}};
        end else if (cnt_r == CNT_LAST) begin
            stableNext_s = synced_s;
            cntNext_s    = {CNT_W{1'b0}};
            commit_s     = 1'b1;
        end else begin
            cntNext_s = cnt_r + CNT_W'(1);
        end
    end

    // Synchroniser chain, counter and stable bit; reset clears the chain too.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_r   <= {SYNC_STAGES{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            stable_r <= 1'b0;
        end else begin
            sync_r   <= {sync_r[SYNC_STAGES-2:0], raw};
            cnt_r    <= cntNext_s;
            stable_r <= stableNext_s;
        end
    end

    assign q      = stable_r;
    assign commit = commit_s;
`ifdef INPUT_EDGE_EN
    assign dir    = synced_s;
`endif

endmodule

// File: rtl/input_debounce_4.sv
// Four-channel synchronise-and-debounce front end feeding merge_bits.
// Define INPUT_EDGE_EN to add per-channel rise/fall pulses.
module input_debounce_4
    import input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SYNC_STAGES     = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       raw_d,
    input  logic       raw_c,
    input  logic       raw_b,
    input  logic       raw_a,
    output logic       bitD,
    output logic       bitC,
    output logic       bitB,
    output logic       bitA,
    output logic       changed
`ifdef INPUT_EDGE_EN
    ,
    output logic [3:0] rise,
    output logic [3:0] fall
`endif
);

    nibble_t raw_s;
    nibble_t stable_s;
    nibble_t commit_s;
    logic    changed_r;

    assign raw_s[CH_D] = raw_d;
    assign raw_s[CH_C] = raw_c;
    assign raw_s[CH_B] = raw_b;
    assign raw_s[CH_A] = raw_a;

`ifdef INPUT_EDGE_EN
    nibble_t dir_s;
    nibble_t rise_r;
    nibble_t fall_r;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : gCh
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .SYNC_STAGES    (SYNC_STAGES)
        ) uCh (
            .clk    (clk),
            .rst_n  (rst_n),
            .raw    (raw_s[i]),
            .q      (stable_s[i]),
            .commit (commit_s[i])
`ifdef INPUT_EDGE_EN
            ,
            .dir    (dir_s[i])
`endif
        );
    end

    // Commits on the same edge collapse into one pulse, aligned with the new bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            changed_r <= 1'b0;
        end else begin
            changed_r <= |commit_s;
        end
    end

`ifdef INPUT_EDGE_EN
    // Direction pulses share the changed timing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rise_r <= {NUM_CH{1'b0}};
            fall_r <= {NUM_CH{1'b0}};
        end else begin
            rise_r <= commit_s & dir_s;
            fall_r <= commit_s & ~dir_s;
        end
    end

    assign rise = rise_r;
    assign fall = fall_r;
`endif

    assign bitD    = stable_s[CH_D];
    assign bitC    = stable_s[CH_C];
    assign bitB    = stable_s[CH_B];
    assign bitA    = stable_s[CH_A];
    assign changed = changed_r;

endmodule
